// File: rtl/multicycle_controller.sv
// Multicycle ARM-like control unit: instruction decode, NZCV flag register,
// condition evaluation and a 10-state sequencer driving the shared-memory datapath.
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUControl,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  flags_q, flags_d;

   logic [3:0]  cond;
   logic [1:0]  op;
   logic        i_bit;
   logic [3:0]  cmd;
   logic        s_bit;
   logic        u_bit;
   logic        l_bit;
   logic [3:0]  rd;
   logic        unused_ok;

   logic        flag_n, flag_z, flag_c, flag_v;
   logic        cond_ex;
   logic        valid_cmd;
   logic        arith_cmd;
   logic [1:0]  cmd_alu;
   logic        rd_is_pc;

   assign cond      = Instr[31:28];
   assign op        = Instr[27:26];
   assign i_bit     = Instr[25];
   assign cmd       = Instr[24:21];
   assign s_bit     = Instr[20];
   assign u_bit     = Instr[23];
   assign l_bit     = Instr[20];
   assign rd        = Instr[15:12];
   assign unused_ok = ^{Instr[19:16], Instr[11:0]};
   assign rd_is_pc  = (rd == 4'd15);

   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Unrecognised commands still flow through EXECUTE/ALUWB but write nothing.
   always_comb begin
      valid_cmd = 1'b1;
      arith_cmd = 1'b0;
      cmd_alu   = 2'b00;
      case (cmd)
         4'b0100: arith_cmd = 1'b1;
         4'b0010: begin cmd_alu = 2'b01; arith_cmd = 1'b1; end
         4'b0000: cmd_alu = 2'b10;
         4'b1100: cmd_alu = 2'b11;
         default: valid_cmd = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               2'b00:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // Logical ops leave C and V untouched; only ADD/SUB produce meaningful carry/overflow.
   always_comb begin
      flags_d = flags_q;
      if (((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) && cond_ex && s_bit && valid_cmd) begin
         flags_d[3:2] = ALUFlags[3:2];
         if (arith_cmd)
            flags_d[1:0] = ALUFlags[1:0];
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 2'b00;
      case (state_q)
         S_FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR: begin
            ALUSrcB    = 2'b01;
            ALUControl = u_bit ? 2'b00 : 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = cond_ex;
            PCWrite   = cond_ex & rd_is_pc;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = cond_ex;
         end
         S_EXECUTER: ALUControl = cmd_alu;
         S_EXECUTEI: begin
            ALUSrcB    = 2'b01;
            ALUControl = cmd_alu;
         end
         S_ALUWB: begin
            RegWrite = cond_ex & valid_cmd;
            PCWrite  = cond_ex & valid_cmd & rd_is_pc;
         end
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = cond_ex;
         end
         default: begin
         end
      endcase
      // State already reads FETCH in reset, so only the write enables need masking.
      if (!reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

   assign ImmSrc = op;
   assign RegSrc = {op == 2'b01, op == 2'b10};
   assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: each step queues the
// expected output word for the current cycle and checks it mid-cycle.
module tb_multicycle_controller;

   logic        clk;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
   logic [1:0]  ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
   logic [3:0]  State;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .AdrSrc     (AdrSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ALUControl (ALUControl),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .State      (State)
   );

   localparam logic [31:0] ADDS  = 32'hE0921003;
   localparam logic [31:0] ADDNE = 32'h10921003;
   localparam logic [31:0] INVS  = 32'hE152F003;
   localparam logic [31:0] SUBS  = 32'hE0521003;
   localparam logic [31:0] ANDS  = 32'hE0121003;
   localparam logic [31:0] ADDPC = 32'hE082F003;
   localparam logic [31:0] LDR   = 32'hE5910004;
   localparam logic [31:0] STR   = 32'hE5010004;
   localparam logic [31:0] BEQ   = 32'h0A000002;
   localparam logic [31:0] BCS   = 32'h2A000002;
   localparam logic [31:0] BMI   = 32'h4A000002;
   localparam logic [31:0] OP11  = 32'hEC000000;

   // Observed word: {State, PCW, IRW, RW, MW, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc}
   logic [19:0] obs;
   assign obs = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};

   typedef struct {
      string       tag;
      logic [19:0] val;
      logic [19:0] care;
   } sb_t;

   sb_t         sb[$];
   logic [19:0] care_next;
   int          n_cmp;
   int          n_bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input string tag, input logic [31:0] instr,
                                input logic [3:0] flags, input logic [19:0] val);
      sb_t e;
      Instr    = instr;
      ALUFlags = flags;
      e.tag    = tag;
      e.val    = val;
      e.care   = care_next;
      care_next = 20'hFFFFF;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      sb_t e;
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("[TB] FAIL scoreboard: observed empty queue, required an entry");
      end else begin
         e = sb.pop_front();
         n_cmp++;
         assert (((obs ^ e.val) & e.care) == 20'h0) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %05h required %05h (care %05h)",
                   e.tag, obs, e.val, e.care);
         end
      end
      @(negedge clk);
   endtask

   task automatic step(input string tag, input logic [31:0] instr, input logic [3:0] flags,
                       input logic [3:0] st, input logic [3:0] en, input logic adr,
                       input logic srca, input logic [1:0] srcb, input logic [1:0] res,
                       input logic [1:0] aluc, input logic [1:0] imm, input logic [1:0] rsrc);
      applyStimulus(tag, instr, flags, {st, en, adr, srca, srcb, res, aluc, imm, rsrc});
      checkOutput();
   endtask

   task automatic fetch(input string tag, input logic [31:0] instr,
                        input logic [1:0] imm, input logic [1:0] rsrc);
      step(tag, instr, 4'h0, 4'd0, 4'b1100, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, imm, rsrc);
   endtask

   task automatic decode(input string tag, input logic [31:0] instr,
                         input logic [1:0] imm, input logic [1:0] rsrc);
      step(tag, instr, 4'h0, 4'd1, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, imm, rsrc);
   endtask

   task automatic branch(input string tag, input logic [31:0] instr, input logic taken);
      fetch({tag, "_f"}, instr, 2'b10, 2'b01);
      decode({tag, "_d"}, instr, 2'b10, 2'b01);
      step({tag, "_br"}, instr, 4'h0, 4'd9, {taken, 3'b000}, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00,
           2'b10, 2'b01);
   endtask

   task automatic dp_reg(input string tag, input logic [31:0] instr, input logic [3:0] flags,
                         input logic [1:0] aluc, input logic [3:0] wb_en);
      fetch({tag, "_f"}, instr, 2'b00, 2'b00);
      decode({tag, "_d"}, instr, 2'b00, 2'b00);
      step({tag, "_ex"}, instr, flags, 4'd6, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, aluc, 2'b00, 2'b00);
      step({tag, "_wb"}, instr, 4'h0, 4'd8, wb_en, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      care_next = 20'hFFFFF;
      reset     = 1'b0;
      Instr     = 32'h0;
      ALUFlags  = 4'h0;
      @(negedge clk);
      step("rst_hold", 32'h0, 4'h0, 4'd0, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
      reset = 1'b1;

      // ADDS sets Z; BEQ then taken
      dp_reg("adds", ADDS, 4'b0100, 2'b00, 4'b0010);
      branch("beq_z1", BEQ, 1'b1);

      // NE fails with Z=1: no write, flags must stay, so BEQ still taken
      dp_reg("addne", ADDNE, 4'b0000, 2'b00, 4'b0000);
      branch("beq_hold", BEQ, 1'b1);

      // Unsupported command with S and Rd=15: no writes, no flag update
      care_next = 20'hFFFCF;
      fetch("inv_f", INVS, 2'b00, 2'b00);
      decode("inv_d", INVS, 2'b00, 2'b00);
      care_next = 20'hFFFCF;
      step("inv_ex", INVS, 4'b0000, 4'd6, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      step("inv_wb", INVS, 4'h0, 4'd8, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      branch("beq_inv", BEQ, 1'b1);

      // LDR aborted by reset entering MEMREAD
      fetch("ldra_f", LDR, 2'b01, 2'b10);
      decode("ldra_d", LDR, 2'b01, 2'b10);
      step("ldra_adr", LDR, 4'h0, 4'd2, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10);
      reset = 1'b0;
      step("rst_mid", LDR, 4'h0, 4'd0, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10);
      step("rst_mid2", LDR, 4'h0, 4'd0, 4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10);
      reset = 1'b1;

      // Full LDR after release
      fetch("ldr_f", LDR, 2'b01, 2'b10);
      decode("ldr_d", LDR, 2'b01, 2'b10);
      step("ldr_adr", LDR, 4'h0, 4'd2, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10);
      step("ldr_rd", LDR, 4'h0, 4'd3, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10);
      step("ldr_wb", LDR, 4'h0, 4'd4, 4'b0010, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10);

      // Reset cleared Z, so BEQ falls through; SUBS sets Z, BEQ taken
      branch("beq_z0", BEQ, 1'b0);
      dp_reg("subs", SUBS, 4'b0100, 2'b01, 4'b0010);
      branch("beq_sub", BEQ, 1'b1);

      // STR with negative offset
      fetch("str_f", STR, 2'b01, 2'b10);
      decode("str_d", STR, 2'b01, 2'b10);
      step("str_adr", STR, 4'h0, 4'd2, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10);
      step("str_wr", STR, 4'h0, 4'd5, 4'b0001, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10);

      // op 11 returns to FETCH straight from DECODE
      fetch("op11_f", OP11, 2'b11, 2'b00);
      decode("op11_d", OP11, 2'b11, 2'b00);

      // ADD to R15 writes the PC in ALUWB
      dp_reg("addpc", ADDPC, 4'b0000, 2'b00, 4'b1010);

      // ANDS loads N,Z only: C stays 0 so BCS fails, N=1 so BMI taken
      dp_reg("ands", ANDS, 4'b1111, 2'b10, 4'b0010);
      branch("bcs", BCS, 1'b0);
      branch("bmi", BMI, 1'b1);
      fetch("end_f", 32'h0, 2'b00, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
